// File: rtl/sprite_overlay_engine_if.sv
// Pixel-stream, configuration and bitmap-write signals for the sprite overlay.
// The pixel source and control side drive through the master modport.
// The overlay engine receives through the slave modport.
interface sprite_overlay_engine_if #(
    parameter int ROW_W   = 5,
    parameter int COL_W   = 6,
    parameter int COLOR_W = 12,
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int SCALE_W = 2
);
    // Pixel stream from the sync counter
    logic [X_W-1:0]         pixel_x;
    logic [Y_W-1:0]         pixel_y;
    logic                   video_on;
    logic                   frame_tick;

    // Shadow configuration load
    logic                   cfg_we;
    logic [X_W-1:0]         cfg_pos_x;
    logic [Y_W-1:0]         cfg_pos_y;
    logic [SCALE_W-1:0]     cfg_scale;
    logic [COLOR_W-1:0]     cfg_color;
    logic                   cfg_enable;
    logic                   cfg_blink;

    // Bitmap write port
    logic                   mem_we;
    logic [ROW_W+COL_W-1:0] mem_addr;
    logic                   mem_din;

    // Overlay result, aligned to the pixel stream
    logic [COLOR_W-1:0]     rgb_out;
    logic                   pixel_hit;
    logic                   video_on_out;

    modport master (
        output pixel_x, pixel_y, video_on, frame_tick,
        output cfg_we, cfg_pos_x, cfg_pos_y, cfg_scale, cfg_color, cfg_enable, cfg_blink,
        output mem_we, mem_addr, mem_din,
        input  rgb_out, pixel_hit, video_on_out
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, frame_tick,
        input  cfg_we, cfg_pos_x, cfg_pos_y, cfg_scale, cfg_color, cfg_enable, cfg_blink,
        input  mem_we, mem_addr, mem_din,
        output rgb_out, pixel_hit, video_on_out
    );
endinterface

// File: rtl/sprite_overlay_engine.sv
// Sprite overlay for the VGA pixel path: a writable 1bpp bitmap placed at a
// programmable position with power-of-two scaling, optional blinking and a
// programmable foreground colour. Output is aligned 3 cycles behind the
// pixel coordinates, independent of scale.
module sprite_overlay_engine #(
    parameter int ROW_W        = 5,
    parameter int COL_W        = 6,
    parameter int COLOR_W      = 12,
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int SCALE_W      = 2,
    parameter int BLINK_FRAMES = 30
) (
    input logic                   clk,
    input logic                   reset,
    sprite_overlay_engine_if.slave bus
);
    localparam int ADDR_W = ROW_W + COL_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef struct packed {
        logic [X_W-1:0]     pos_x;
        logic [Y_W-1:0]     pos_y;
        logic [SCALE_W-1:0] scale;
        logic [COLOR_W-1:0] color;
        logic               enable;
        logic               blink;
    } cfg_t;

    cfg_t cfg_in;
    cfg_t shadow_cfg;
    cfg_t active_cfg;

    logic [CNT_W-1:0]  blink_cnt;
    logic              visible;

    logic [X_W:0]      dx_full;
    logic [Y_W:0]      dy_full;
    logic [X_W-1:0]    dx_s;
    logic [Y_W-1:0]    dy_s;
    logic              in_box_c;
    logic [ADDR_W-1:0] rd_addr_c;

    logic [ADDR_W-1:0] rd_addr_q;
    logic              in_box_d1;
    logic              video_on_d1;

    logic              bitmap [DEPTH];
    logic              bit_q;
    logic              in_box_d2;
    logic              video_on_d2;

    logic              hit_c;
    logic [COLOR_W-1:0] rgb_q;
    logic              hit_q;
    logic              video_on_q;

    // Gather the incoming configuration fields into one record
    always_comb begin
        cfg_in = '{
            pos_x:  bus.cfg_pos_x,
            pos_y:  bus.cfg_pos_y,
            scale:  bus.cfg_scale,
            color:  bus.cfg_color,
            enable: bus.cfg_enable,
            blink:  bus.cfg_blink
        };
    end

    // Double-buffered config: shadow loads any time, active only at frame start
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            shadow_cfg <= '0;
            active_cfg <= '0;
        end else begin
            if (bus.cfg_we) begin
                shadow_cfg <= cfg_in;
            end
            if (bus.frame_tick) begin
                active_cfg <= bus.cfg_we ? cfg_in : shadow_cfg;
            end
        end
    end

    // Blink timer: toggles visibility every BLINK_FRAMES frames while blinking
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
            visible   <= 1'b1;
        end else if (!active_cfg.blink) begin
            blink_cnt <= '0;
            visible   <= 1'b1;
        end else if (bus.frame_tick) begin
            if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                visible   <= ~visible;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Stage 0 combinational: sprite-relative offset, box test and bitmap address
    always_comb begin
        // NOTE: every output of this block is assigned on every path, so no
        // latch can be inferred.
        dx_full   = {1'b0, bus.pixel_x} - {1'b0, active_cfg.pos_x};
        dy_full   = {1'b0, bus.pixel_y} - {1'b0, active_cfg.pos_y};
        dx_s      = dx_full[X_W-1:0] >> active_cfg.scale;
        dy_s      = dy_full[Y_W-1:0] >> active_cfg.scale;
        // A borrow in the top bit means the pixel is left of / above the sprite;
        // (d >> scale) < 2^N is the same test as d < (2^N << scale).
        in_box_c  = !dx_full[X_W] && !dy_full[Y_W]
                    && ((dx_s >> COL_W) == '0) && ((dy_s >> ROW_W) == '0);
        rd_addr_c = {dy_s[ROW_W-1:0], dx_s[COL_W-1:0]};
    end

    // Stage 0 register
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_q   <= '0;
            in_box_d1   <= 1'b0;
            video_on_d1 <= 1'b0;
        end else begin
            rd_addr_q   <= rd_addr_c;
            in_box_d1   <= in_box_c;
            video_on_d1 <= bus.video_on;
        end
    end

    // Stage 1: bitmap RAM with synchronous read, old data on read-during-write
    always_ff @(posedge clk) begin
        // NOTE: the bitmap has no reset so it maps onto block RAM; its contents
        // persist across reset.
        if (bus.mem_we) begin
            bitmap[bus.mem_addr] <= bus.mem_din;
        end
        bit_q <= bitmap[rd_addr_q];
    end

    // Stage 1: qualifier delay chain in parallel with the RAM read
    always_ff @(posedge clk) begin
        if (reset) begin
            in_box_d2   <= 1'b0;
            video_on_d2 <= 1'b0;
        end else begin
            in_box_d2   <= in_box_d1;
            video_on_d2 <= video_on_d1;
        end
    end

    // Stage 2 combinational: final hit decision
    always_comb begin
        hit_c = video_on_d2 & in_box_d2 & bit_q & active_cfg.enable & visible;
    end

    // Stage 2 output register
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q      <= '0;
            hit_q      <= 1'b0;
            video_on_q <= 1'b0;
        end else begin
            rgb_q      <= hit_c ? active_cfg.color : '0;
            hit_q      <= hit_c;
            video_on_q <= video_on_d2;
        end
    end

    assign bus.rgb_out      = rgb_q;
    assign bus.pixel_hit    = hit_q;
    assign bus.video_on_out = video_on_q;

endmodule

// File: tb/tb_sprite_overlay_engine.sv
// Self-checking bench for sprite_overlay_engine: directed scenarios plus a
// randomized back-to-back pixel stream compared against a behavioural model.
module tb_sprite_overlay_engine;
    localparam int ROW_W   = 5;
    localparam int COL_W   = 6;
    localparam int COLOR_W = 12;
    localparam int X_W     = 10;
    localparam int Y_W     = 10;
    localparam int SCALE_W = 2;
    localparam int BF      = 2;
    localparam int W       = 1 << COL_W;
    localparam int H       = 1 << ROW_W;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sprite_overlay_engine_if #(
        .ROW_W(ROW_W), .COL_W(COL_W), .COLOR_W(COLOR_W),
        .X_W(X_W), .Y_W(Y_W), .SCALE_W(SCALE_W)
    ) bus_if ();

    sprite_overlay_engine #(
        .ROW_W(ROW_W), .COL_W(COL_W), .COLOR_W(COLOR_W),
        .X_W(X_W), .Y_W(Y_W), .SCALE_W(SCALE_W), .BLINK_FRAMES(BF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: bitmap contents and shadow/active configuration
    bit bmp [W*H];
    int sh_px, sh_py, sh_sc, sh_col;
    bit sh_en, sh_bl;
    int ac_px, ac_py, ac_sc, ac_col;
    bit ac_en, ac_bl;
    bit m_vis = 1'b1;

    function automatic bit model_hit(int x, int y, bit von);
        int w, h, col, row;
        w = W << ac_sc;
        h = H << ac_sc;
        if (!(von && ac_en && m_vis)) return 1'b0;
        if (x < ac_px || x >= ac_px + w || y < ac_py || y >= ac_py + h) return 1'b0;
        col = (x - ac_px) >> ac_sc;
        row = (y - ac_py) >> ac_sc;
        return bmp[row*W + col];
    endfunction

    task automatic model_reset();
        sh_px = 0; sh_py = 0; sh_sc = 0; sh_col = 0; sh_en = 0; sh_bl = 0;
        ac_px = 0; ac_py = 0; ac_sc = 0; ac_col = 0; ac_en = 0; ac_bl = 0;
        m_vis = 1'b1;
    endtask

    task automatic idle_inputs();
        bus_if.pixel_x    = '0;
        bus_if.pixel_y    = '0;
        bus_if.video_on   = 1'b0;
        bus_if.frame_tick = 1'b0;
        bus_if.cfg_we     = 1'b0;
        bus_if.cfg_pos_x  = '0;
        bus_if.cfg_pos_y  = '0;
        bus_if.cfg_scale  = '0;
        bus_if.cfg_color  = '0;
        bus_if.cfg_enable = 1'b0;
        bus_if.cfg_blink  = 1'b0;
        bus_if.mem_we     = 1'b0;
        bus_if.mem_addr   = '0;
        bus_if.mem_din    = 1'b0;
    endtask

    // All stimulus tasks start and end just after a falling edge
    task automatic cfg_load(int px, int py, int sc, int col, bit en, bit bl, bit tick);
        bus_if.cfg_we     = 1'b1;
        bus_if.cfg_pos_x  = X_W'(px);
        bus_if.cfg_pos_y  = Y_W'(py);
        bus_if.cfg_scale  = SCALE_W'(sc);
        bus_if.cfg_color  = COLOR_W'(col);
        bus_if.cfg_enable = en;
        bus_if.cfg_blink  = bl;
        bus_if.frame_tick = tick;
        @(negedge clk);
        bus_if.cfg_we     = 1'b0;
        bus_if.frame_tick = 1'b0;
        sh_px = px; sh_py = py; sh_sc = sc; sh_col = col; sh_en = en; sh_bl = bl;
        if (tick) begin
            ac_px = px; ac_py = py; ac_sc = sc; ac_col = col; ac_en = en; ac_bl = bl;
        end
    endtask

    task automatic frame_pulse();
        bus_if.frame_tick = 1'b1;
        @(negedge clk);
        bus_if.frame_tick = 1'b0;
        ac_px = sh_px; ac_py = sh_py; ac_sc = sh_sc; ac_col = sh_col;
        ac_en = sh_en; ac_bl = sh_bl;
    endtask

    task automatic mem_write(int addr, bit b);
        bus_if.mem_we   = 1'b1;
        bus_if.mem_addr = (ROW_W+COL_W)'(addr);
        bus_if.mem_din  = b;
        @(negedge clk);
        bus_if.mem_we   = 1'b0;
        bmp[addr] = b;
    endtask

    // Presents one pixel for one cycle and returns when its result is on the outputs
    task automatic send_pixel(int x, int y, bit von);
        bus_if.pixel_x  = X_W'(x);
        bus_if.pixel_y  = Y_W'(y);
        bus_if.video_on = von;
        @(negedge clk);
        bus_if.pixel_x  = '0;
        bus_if.pixel_y  = '0;
        bus_if.video_on = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.pixel_x  = 10'd100;
        bus_if.pixel_y  = 10'd50;
        bus_if.video_on = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({bus_if.rgb_out, bus_if.pixel_hit, bus_if.video_on_out} !== '0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: rgb=%h hit=%b von=%b, wanted all zero",
                         k, bus_if.rgb_out, bus_if.pixel_hit, bus_if.video_on_out);
            end
        end
        reset = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
    endtask

    task automatic fill_bitmap_random();
        for (int i = 0; i < W*H; i++) begin
            bit b;
            b = 1'($urandom_range(0, 1));
            if (i == 0 || i == W-1 || (i >= 23 && i <= 31)) b = 1'b1;
            if (i == 1) b = 1'b0;
            mem_write(i, b);
        end
    endtask

    task automatic test_basic();
        int xs [4] = '{100, 101, 99, 100};
        int ys [4] = '{50, 50, 50, 49};
        bit ex [4] = '{1, 0, 0, 0};
        cfg_load(100, 50, 0, 12'hCF7, 1'b1, 1'b0, 1'b0);
        frame_pulse();
        for (int i = 0; i < 4; i++) begin
            send_pixel(xs[i], ys[i], 1'b1);
            checks++;
            if (bus_if.pixel_hit !== ex[i] || bus_if.rgb_out !== (ex[i] ? 12'hCF7 : 12'h000)
                || bus_if.video_on_out !== 1'b1) begin
                errors++;
                $display("FAIL basic(%0d,%0d): hit=%b rgb=%h von=%b, wanted hit=%b rgb=%h von=1",
                         xs[i], ys[i], bus_if.pixel_hit, bus_if.rgb_out, bus_if.video_on_out,
                         ex[i], ex[i] ? 12'hCF7 : 12'h000);
            end
        end
    endtask

    task automatic test_scale();
        int xs [6] = '{100, 101, 102, 227, 228, 100};
        int ys [6] = '{50, 51, 50, 50, 50, 114};
        bit ex [6] = '{1, 1, 0, 1, 0, 0};
        cfg_load(100, 50, 1, 12'hCF7, 1'b1, 1'b0, 1'b0);
        frame_pulse();
        for (int i = 0; i < 6; i++) begin
            send_pixel(xs[i], ys[i], 1'b1);
            checks++;
            if (bus_if.pixel_hit !== ex[i] || bus_if.rgb_out !== (ex[i] ? 12'hCF7 : 12'h000)) begin
                errors++;
                $display("FAIL scale1(%0d,%0d): hit=%b rgb=%h, wanted hit=%b",
                         xs[i], ys[i], bus_if.pixel_hit, bus_if.rgb_out, ex[i]);
            end
        end
    endtask

    task automatic test_double_buffer();
        int xs [6] = '{100, 200, 100, 200, 300, 200};
        int ys [6] = '{50, 50, 50, 50, 60, 50};
        bit ex [6] = '{1, 0, 0, 1, 1, 0};
        cfg_load(100, 50, 0, 12'hCF7, 1'b1, 1'b0, 1'b1);
        cfg_load(200, 50, 0, 12'hCF7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) frame_pulse();
            if (i == 4) cfg_load(300, 60, 0, 12'h5A3, 1'b1, 1'b0, 1'b1);
            send_pixel(xs[i], ys[i], 1'b1);
            checks++;
            if (bus_if.pixel_hit !== ex[i] || bus_if.rgb_out !== (ex[i] ? COLOR_W'(ac_col) : '0)) begin
                errors++;
                $display("FAIL dbuf[%0d](%0d,%0d): hit=%b rgb=%h, wanted hit=%b rgb=%h",
                         i, xs[i], ys[i], bus_if.pixel_hit, bus_if.rgb_out, ex[i],
                         ex[i] ? COLOR_W'(ac_col) : COLOR_W'(0));
            end
        end
    endtask

    task automatic test_screen_edge();
        cfg_load(1000, 50, 0, 12'hCF7, 1'b1, 1'b0, 1'b1);
        send_pixel(1023, 50, 1'b1);
        checks++;
        if (bus_if.pixel_hit !== 1'b1 || bus_if.rgb_out !== 12'hCF7) begin
            errors++;
            $display("FAIL edge_col23: hit=%b rgb=%h, wanted hit=1 rgb=cf7",
                     bus_if.pixel_hit, bus_if.rgb_out);
        end
        for (int x = 0; x < 8; x++) begin
            send_pixel(x, 50, 1'b1);
            checks++;
            if (bus_if.pixel_hit !== 1'b0 || bus_if.rgb_out !== 12'h000) begin
                errors++;
                $display("FAIL edge_nowrap x=%0d: hit=%b rgb=%h, wanted no hit",
                         x, bus_if.pixel_hit, bus_if.rgb_out);
            end
        end
        send_pixel(1023, 50, 1'b0);
        checks++;
        if (bus_if.pixel_hit !== 1'b0 || bus_if.rgb_out !== 12'h000 || bus_if.video_on_out !== 1'b0) begin
            errors++;
            $display("FAIL edge_blanked: hit=%b rgb=%h von=%b, wanted all zero",
                     bus_if.pixel_hit, bus_if.rgb_out, bus_if.video_on_out);
        end
    endtask

    task automatic test_reset_mid();
        int xs [3] = '{100, 101, 99};
        bit ex [3] = '{1, 0, 0};
        cfg_load(100, 50, 0, 12'hCF7, 1'b1, 1'b0, 1'b1);
        bus_if.pixel_x  = 10'd100;
        bus_if.pixel_y  = 10'd50;
        bus_if.video_on = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_if.pixel_hit !== 1'b1 || bus_if.rgb_out !== 12'hCF7) begin
            errors++;
            $display("FAIL pre_reset_stream: hit=%b rgb=%h, wanted hit=1 rgb=cf7",
                     bus_if.pixel_hit, bus_if.rgb_out);
        end
        reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                reset = 1'b0;
                model_reset();
            end
            checks++;
            if (bus_if.pixel_hit !== 1'b0 || bus_if.rgb_out !== 12'h000
                || bus_if.video_on_out !== (k == 4)) begin
                errors++;
                $display("FAIL reset_refill[%0d]: hit=%b rgb=%h von=%b, wanted hit=0 rgb=000 von=%b",
                         k, bus_if.pixel_hit, bus_if.rgb_out, bus_if.video_on_out, k == 4);
            end
        end
        idle_inputs();
        @(negedge clk);
        cfg_load(100, 50, 0, 12'hCF7, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_pixel(xs[i], 50, 1'b1);
            checks++;
            if (bus_if.pixel_hit !== ex[i] || bus_if.rgb_out !== (ex[i] ? 12'hCF7 : 12'h000)) begin
                errors++;
                $display("FAIL post_reset(%0d,50): hit=%b rgb=%h, wanted hit=%b",
                         xs[i], bus_if.pixel_hit, bus_if.rgb_out, ex[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            int x, y;
            bit e;
            x = 100 + $urandom_range(0, W-1);
            y = 50 + $urandom_range(0, H-1);
            e = model_hit(x, y, 1'b1);
            send_pixel(x, y, 1'b1);
            checks++;
            if (bus_if.pixel_hit !== e) begin
                errors++;
                $display("FAIL bitmap_kept(%0d,%0d): hit=%b, wanted %b", x, y, bus_if.pixel_hit, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 300;
        bit e_hit [N];
        bit e_von [N];
        int sc;
        sc = $urandom_range(0, 3);
        cfg_load(100, 50, sc, 12'h3B9, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < N + 3; i++) begin
            if (i >= 3) begin
                checks++;
                if (bus_if.pixel_hit !== e_hit[i-3] || bus_if.video_on_out !== e_von[i-3]
                    || bus_if.rgb_out !== (e_hit[i-3] ? 12'h3B9 : 12'h000)) begin
                    errors++;
                    $display("FAIL stream[%0d] scale=%0d: hit=%b rgb=%h von=%b, wanted hit=%b von=%b",
                             i-3, sc, bus_if.pixel_hit, bus_if.rgb_out, bus_if.video_on_out,
                             e_hit[i-3], e_von[i-3]);
                end
            end
            if (i < N) begin
                int x, y;
                bit v;
                x = $urandom_range(90, 100 + (W << sc) + 10);
                y = $urandom_range(40, 50 + (H << sc) + 10);
                v = ($urandom_range(0, 7) != 0);
                e_hit[i] = model_hit(x, y, v);
                e_von[i] = v;
                bus_if.pixel_x  = X_W'(x);
                bus_if.pixel_y  = Y_W'(y);
                bus_if.video_on = v;
            end else begin
                bus_if.video_on = 1'b0;
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_blink();
        for (int i = 0; i < W*H; i++) mem_write(i, 1'b1);
        cfg_load(100, 50, 0, 12'hCF7, 1'b1, 1'b1, 1'b1);
        for (int f = 0; f < 7; f++) begin
            bit e;
            e = ((f / BF) % 2) == 0;
            send_pixel(100, 50, 1'b1);
            checks++;
            if (bus_if.pixel_hit !== e) begin
                errors++;
                $display("FAIL blink_frame%0d: hit=%b, wanted %b", f, bus_if.pixel_hit, e);
            end
            if (f < 6) frame_pulse();
        end
        cfg_load(100, 50, 0, 12'hCF7, 1'b1, 1'b0, 1'b0);
        send_pixel(100, 50, 1'b1);
        checks++;
        if (bus_if.pixel_hit !== 1'b0) begin
            errors++;
            $display("FAIL blink_shadow_only: hit=%b, wanted 0", bus_if.pixel_hit);
        end
        frame_pulse();
        send_pixel(100, 50, 1'b1);
        checks++;
        if (bus_if.pixel_hit !== 1'b1 || bus_if.rgb_out !== 12'hCF7) begin
            errors++;
            $display("FAIL blink_cleared: hit=%b rgb=%h, wanted hit=1 rgb=cf7",
                     bus_if.pixel_hit, bus_if.rgb_out);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        test_reset();
        fill_bitmap_random();
        test_basic();
        test_scale();
        test_double_buffer();
        test_screen_edge();
        test_reset_mid();
        test_back_to_back();
        test_blink();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_overlay_engine.md
Name: sprite_overlay_engine

Overview:
Parametrised, pipelined sprite overlay for the VGA pixel path, replacing the fixed per-message colour ROMs. It holds a writable 1-bit-per-pixel bitmap, places it at a programmable screen position with integer scaling, optional blinking and a programmable foreground colour. It outputs the overlay colour aligned to the pixel stream with fixed latency. It sits between the VGA sync counter and the final colour mux.

Parameters:
ROW_W, 5, bitmap row address width (height = 2^ROW_W)
COL_W, 6, bitmap column address width (width = 2^COL_W)
COLOR_W, 12, colour width (RGB444)
X_W, 10, pixel_x / pos_x width
Y_W, 10, pixel_y / pos_y width
SCALE_W, 2, scale exponent width (scale factor = 2^scale)
BLINK_FRAMES, 30, frames per blink half-period (>=1)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
pixel_x  in  X_W  current pixel column from sync counter
pixel_y  in  Y_W  current pixel row
video_on  in  1  active display region
frame_tick  in  1  one-cycle pulse at start of vertical blank
cfg_we  in  1  load shadow config registers
cfg_pos_x  in  X_W  sprite left edge
cfg_pos_y  in  Y_W  sprite top edge
cfg_scale  in  SCALE_W  scale exponent
cfg_color  in  COLOR_W  foreground colour
cfg_enable  in  1  sprite visible
cfg_blink  in  1  blink enable
mem_we  in  1  bitmap write strobe
mem_addr  in  ROW_W+COL_W  bitmap address {row,col}
mem_din  in  1  bitmap bit
rgb_out  out  COLOR_W  overlay colour, 0 when no hit
pixel_hit  out  1  overlay pixel is lit
video_on_out  out  1  video_on delayed to match rgb_out

Behaviour:
- Config: cfg_we loads all cfg_* into shadow registers. frame_tick copies shadow to active. If cfg_we and frame_tick occur in the same cycle, the new cfg values go to both shadow and active that cycle. Active registers alone drive rendering, so there is no mid-frame tearing.
- Stage 0 (comb + reg):
  - dx = pixel_x - pos_x and dy = pixel_y - pos_y, computed at width+1 so that a borrow means outside.
  - in_box = no borrow on either && dx < (2^COL_W << scale) && dy < (2^ROW_W << scale).
  - Comparisons are done at full width; there is no wrap at the screen edge.
  - rd_addr = {dy>>scale, dx>>scale} (truncated to ROW_W / COL_W).
  - Registered: rd_addr, in_box, video_on.
- Stage 1: synchronous bitmap read (block RAM inference, 2^(ROW_W+COL_W) x 1). The in_box and video_on delay chain advances in parallel.
- Stage 2:
  - hit = video_on_d2 & in_box_d2 & bit & enable & visible.
  - Registered outputs: rgb_out = hit ? color : 0; pixel_hit = hit; video_on_out = video_on_d2.
- Latency: inputs at cycle t produce outputs at cycle t+3 (registered after stage 2). The latency is fixed and independent of scale.
- Bitmap write: mem_we writes mem_din at mem_addr. A read-during-write to the same address returns the old data. The bitmap is not cleared by reset.
- Blink:
  - blink_cnt counts frame_tick pulses from 0 to BLINK_FRAMES-1, then wraps to 0 and toggles the visible flag.
  - When the active blink bit is 0: visible forced to 1 and blink_cnt held at 0.
  - When blink goes 1: blinking starts visible.
- Reset, on the first clock edge with reset high:
  - rgb_out = 0, pixel_hit = 0, video_on_out = 0, pipeline valid bits = 0.
  - Shadow and active registers: pos 0, scale 0, color 0, enable 0, blink 0.
  - visible = 1, blink_cnt = 0.
  - Reset mid-line: outputs are 0 from the next cycle until the pipeline refills after reset is released (3 cycles).
- cfg_scale is any value within SCALE_W. A box extending past the max coordinate is simply clipped; nothing wraps.

Test Plan:
1. Reset, write bitmap (0,0)=1 and (0,1)=0. Load cfg pos=(100,50), scale=0, color=12'hCF7, enable=1, then pulse frame_tick. Drive pixel (100,50) with video_on=1 -> 3 cycles later rgb_out=12'hCF7, pixel_hit=1. Pixel (101,50) -> rgb_out=0. Pixel (99,50) -> 0.
2. As 1 with scale=1: pixels (100,50), (101,51) -> hit; pixel (102,50) -> no hit (maps to col 1). Pixel (100+127, 50) -> tests the last column of the box; (100+128, 50) -> no hit regardless of bitmap.
3. Mid-frame cfg_we with pos=(200,50), no frame_tick: pixel (100,50) still hits. After frame_tick, (100,50) -> 0 and (200,50) -> hit. Simultaneous cfg_we + frame_tick -> applied immediately.
4. Bench BLINK_FRAMES=2, blink=1, all-ones bitmap: hits present for frames 0-1, absent for frames 2-3, present for frames 4-5. Clear blink -> visible on the next frame.
5. pos_x=1000, X_W=10, COL_W=6: pixel_x 1023 -> hit on col 23. pixel_x 0-7 -> no hit (no wrap). video_on=0 inside the box -> rgb_out=0.
6. Assert reset for 1 cycle mid-stream during hits -> outputs 0 the next cycle and enable=0. Bitmap contents survive: reconfigure without rewriting and get the same hit pattern as scenario 1.
